// File: rtl/funprof_pkg.sv
// funprof_pkg: shared state encoding, stack entry type and defaults for the profiler scheduler.
package funprof_pkg;
   localparam int NUM_SLOTS_DEF   = 4;
   localparam int STACK_DEPTH_DEF = 8;
   localparam int SLOT_W_MAX      = 8;
   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RUN, S_HALT, S_CLEAR} state_e;
   // slot is sized for the widest supported slot index; narrower designs zero-extend
   typedef struct packed {
      logic                  valid;
      logic [SLOT_W_MAX-1:0] slot;
   } entry_t;
endpackage

// File: rtl/funprof_sched_if.sv
// funprof_sched_if: trace, host-command and counter-control signals of the profiler scheduler.
interface funprof_sched_if #(
   parameter int NUM_SLOTS = 4,
   parameter int SLOT_W    = 2,
   parameter int DEPTH_W   = 4
);
   logic                 call;
   logic                 ret;
   logic                 call_hit;
   logic [SLOT_W-1:0]    call_slot;
   logic                 ctl_start;
   logic                 ctl_stop;
   logic                 ctl_clear;
   logic [NUM_SLOTS-1:0] cnt_enable;
   logic                 cnt_clear;
   logic                 busy;
   logic [DEPTH_W-1:0]   depth;
   logic                 err_ovf;
   modport master (
      output call, ret, call_hit, call_slot, ctl_start, ctl_stop, ctl_clear,
      input  cnt_enable, cnt_clear, busy, depth, err_ovf
   );
   modport slave (
      input  call, ret, call_hit, call_slot, ctl_start, ctl_stop, ctl_clear,
      output cnt_enable, cnt_clear, busy, depth, err_ovf
   );
endinterface

// File: rtl/funprof_stack.sv
// funprof_stack: register-based call LIFO; nxt_top_o is the top entry as it will be after this edge.
module funprof_stack
   import funprof_pkg::*;
#(
   parameter int STACK_DEPTH = STACK_DEPTH_DEF,
   parameter int DEPTH_W     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush_i,
   input  logic               push_i,
   input  logic               pop_i,
   input  entry_t             push_data_i,
   output entry_t             nxt_top_o,
   output logic [DEPTH_W-1:0] depth_o,
   output logic               full_o
);
   localparam int AW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
   entry_t             mem_q [STACK_DEPTH];
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [AW-1:0]      wr_idx, top_idx, below_idx;
   logic               do_push, do_pop;
   entry_t             top;
   assign full_o    = depth_q == DEPTH_W'(STACK_DEPTH);
   assign depth_o   = depth_q;
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !do_push && depth_q != '0;
   assign wr_idx    = AW'(depth_q);
   assign top_idx   = AW'(depth_q - DEPTH_W'(1));
   assign below_idx = AW'(depth_q - DEPTH_W'(2));
   assign top       = depth_q != '0 ? mem_q[top_idx] : '0;
   always_comb begin
      nxt_top_o = flush_i ? '0 : do_push ? push_data_i :
                  do_pop ? (depth_q > DEPTH_W'(1) ? mem_q[below_idx] : '0) : top;
      depth_d   = flush_i ? '0 : do_push ? depth_q + DEPTH_W'(1) :
                  do_pop ? depth_q - DEPTH_W'(1) : depth_q;
   end
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         depth_q <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         depth_q <= depth_d;
         if (do_push) mem_q[wr_idx] <= push_data_i;
         if (do_pop) mem_q[top_idx].valid <= 1'b0;
      end
   end
endmodule

// File: rtl/funprof_sched.sv
// funprof_sched: tracks call nesting and enables only the innermost profiled function's counter.
module funprof_sched
   import funprof_pkg::*;
#(
   parameter int NUM_SLOTS   = NUM_SLOTS_DEF,
   parameter int SLOT_W      = 2,
   parameter int STACK_DEPTH = STACK_DEPTH_DEF,
   parameter int DEPTH_W     = 4
) (
   input logic            clk,
   input logic            reset,
   funprof_sched_if.slave bus
);
   state_e               state_q, state_d;
   entry_t               push_data, nxt_top;
   logic                 push, pop, flush, full, ovf_set, hit_ok;
   logic [DEPTH_W-1:0]   depth;
   logic [NUM_SLOTS-1:0] en_q, en_d;
   logic                 err_q, err_d;
   // out-of-range slots count as untracked calls so returns stay balanced
   assign hit_ok    = bus.call_hit && ({1'b0, bus.call_slot} < (SLOT_W+1)'(NUM_SLOTS));
   assign push_data = '{valid: hit_ok, slot: SLOT_W_MAX'(bus.call_slot)};
   funprof_stack #(.STACK_DEPTH(STACK_DEPTH), .DEPTH_W(DEPTH_W)) u_stack (
      .clk(clk), .rst(reset), .flush_i(flush), .push_i(push), .pop_i(pop),
      .push_data_i(push_data), .nxt_top_o(nxt_top), .depth_o(depth), .full_o(full)
   );
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      pop     = 1'b0;
      flush   = 1'b0;
      ovf_set = 1'b0;
      if (state_q == S_CLEAR) begin
         flush   = 1'b1;
         state_d = bus.ctl_clear ? S_CLEAR : S_IDLE;
      end else if (bus.ctl_clear) begin
         state_d = S_CLEAR;
      end else if (bus.ctl_stop) begin
         flush   = 1'b1;
         state_d = S_IDLE;
      end else if (bus.ctl_start) begin
         state_d = state_q == S_IDLE ? S_ARMED : state_q;
      end else if (state_q == S_ARMED && bus.call && hit_ok) begin
         push    = 1'b1;
         state_d = S_RUN;
      end else if (state_q == S_RUN && bus.call) begin
         push    = !full;
         ovf_set = full;
         state_d = full ? S_HALT : S_RUN;
      end else if (state_q == S_RUN && bus.ret) begin
         pop     = 1'b1;
         state_d = depth == DEPTH_W'(1) ? S_ARMED : S_RUN;
      end
      err_d = state_q == S_CLEAR ? 1'b0 : err_q | ovf_set;
      en_d  = (state_d == S_RUN && nxt_top.valid) ? NUM_SLOTS'(1) << nxt_top.slot : '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         en_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         err_q   <= err_d;
      end
   end
   assign bus.cnt_enable = en_q;
   assign bus.cnt_clear  = state_q == S_CLEAR;
   assign bus.busy       = state_q != S_IDLE;
   assign bus.depth      = depth;
   assign bus.err_ovf    = err_q;
endmodule

// File: tb/tb_funprof_sched.sv
// tb_funprof_sched: directed vector table, corner sequences and random traffic against a queue model.
module tb_funprof_sched;
   localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_HALT = 3, M_CLEAR = 4;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0, n_fail = 0;
   int   m_mode = M_IDLE;
   int   stk[$];
   bit   m_err = 1'b0;
   always #5 clk = ~clk;
   funprof_sched_if #(.NUM_SLOTS(4), .SLOT_W(2), .DEPTH_W(4)) bus ();
   funprof_sched_if #(.NUM_SLOTS(3), .SLOT_W(2), .DEPTH_W(4)) bus3 ();
   funprof_sched #(.NUM_SLOTS(4), .SLOT_W(2), .STACK_DEPTH(8), .DEPTH_W(4)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   funprof_sched #(.NUM_SLOTS(3), .SLOT_W(2), .STACK_DEPTH(8), .DEPTH_W(4)) dut3 (
      .clk(clk), .reset(reset), .bus(bus3)
   );
   assign bus3.call      = bus.call;
   assign bus3.ret       = bus.ret;
   assign bus3.call_hit  = bus.call_hit;
   assign bus3.call_slot = bus.call_slot;
   assign bus3.ctl_start = bus.ctl_start;
   assign bus3.ctl_stop  = bus.ctl_stop;
   assign bus3.ctl_clear = bus.ctl_clear;
   typedef struct {
      logic       rs, st, sp, cl, c, r, h;
      logic [1:0] s;
      logic [3:0] en, dp;
      logic       bz, er, cc;
   } vec_t;
   vec_t vt[$];
   function automatic vec_t v(logic rs, st, sp, cl, c, r, h, logic [1:0] s,
                              logic [3:0] en, dp, logic bz, er, cc);
      vec_t x;
      x = '{rs, st, sp, cl, c, r, h, s, en, dp, bz, er, cc};
      return x;
   endfunction
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask
   // reference behaviour: the call stack is a queue of slots, -1 marks an untracked call
   task automatic model(input logic rs, st, sp, cl, c, r, h, input int s);
      bit hit;
      hit = h && s < 4;
      if (rs) begin
         m_mode = M_IDLE; stk.delete(); m_err = 1'b0;
      end else if (m_mode == M_CLEAR) begin
         stk.delete(); m_err = 1'b0; m_mode = cl ? M_CLEAR : M_IDLE;
      end else if (cl) begin
         m_mode = M_CLEAR;
      end else if (sp) begin
         m_mode = M_IDLE; stk.delete();
      end else if (st) begin
         if (m_mode == M_IDLE) m_mode = M_ARMED;
      end else if (m_mode == M_ARMED && c && hit) begin
         stk.push_back(s); m_mode = M_RUN;
      end else if (m_mode == M_RUN && c) begin
         if (stk.size() == 8) begin
            m_err = 1'b1; m_mode = M_HALT;
         end else stk.push_back(hit ? s : -1);
      end else if (m_mode == M_RUN && r) begin
         void'(stk.pop_back());
         if (stk.size() == 0) m_mode = M_ARMED;
      end
   endtask
   task automatic cyc(input logic rs, st, sp, cl, c, r, h, input logic [1:0] s);
      int ee;
      @(negedge clk);
      reset = rs; bus.ctl_start = st; bus.ctl_stop = sp; bus.ctl_clear = cl;
      bus.call = c; bus.ret = r; bus.call_hit = h; bus.call_slot = s;
      @(posedge clk);
      model(rs, st, sp, cl, c, r, h, int'(s));
      #1;
      ee = (m_mode == M_RUN && stk.size() > 0 && stk[$] >= 0) ? (1 << stk[$]) : 0;
      chk("model_cnt_enable", 32'(bus.cnt_enable), ee);
      chk("model_depth", 32'(bus.depth), stk.size());
      chk("model_busy", 32'(bus.busy), 32'(m_mode != M_IDLE));
      chk("model_err_ovf", 32'(bus.err_ovf), 32'(m_err));
      chk("model_cnt_clear", 32'(bus.cnt_clear), 32'(m_mode == M_CLEAR));
   endtask
   initial begin
      logic rs, st, sp, cl, c, r, h;
      logic [1:0] s;
      reset = 1'b1; bus.ctl_start = 0; bus.ctl_stop = 0; bus.ctl_clear = 0;
      bus.call = 0; bus.ret = 0; bus.call_hit = 0; bus.call_slot = 0;
      vt.push_back(v(1,0,0,0,0,0,0,0, 4'b0000,0,0,0,0));
      vt.push_back(v(0,1,0,0,0,0,0,0, 4'b0000,0,1,0,0));
      vt.push_back(v(0,0,0,0,1,0,1,2, 4'b0100,1,1,0,0));
      for (int i = 0; i < 9; i++) vt.push_back(v(0,0,0,0,0,0,0,0, 4'b0100,1,1,0,0));
      vt.push_back(v(0,0,0,0,0,1,0,0, 4'b0000,0,1,0,0));
      vt.push_back(v(0,0,0,0,0,1,0,0, 4'b0000,0,1,0,0));
      vt.push_back(v(0,0,0,0,1,0,0,1, 4'b0000,0,1,0,0));
      vt.push_back(v(0,0,0,0,1,0,1,1, 4'b0010,1,1,0,0));
      vt.push_back(v(0,0,0,0,1,0,0,0, 4'b0000,2,1,0,0));
      vt.push_back(v(0,0,0,0,1,0,1,3, 4'b1000,3,1,0,0));
      vt.push_back(v(0,0,0,0,0,1,0,0, 4'b0000,2,1,0,0));
      vt.push_back(v(0,0,0,0,0,1,0,0, 4'b0010,1,1,0,0));
      vt.push_back(v(0,0,0,0,0,1,0,0, 4'b0000,0,1,0,0));
      vt.push_back(v(0,0,0,0,1,0,1,0, 4'b0001,1,1,0,0));
      vt.push_back(v(0,0,0,0,1,1,1,2, 4'b0100,2,1,0,0));
      vt.push_back(v(0,0,1,0,1,0,1,1, 4'b0000,0,0,0,0));
      vt.push_back(v(0,1,0,0,0,0,0,0, 4'b0000,0,1,0,0));
      vt.push_back(v(0,0,0,0,1,0,1,3, 4'b1000,1,1,0,0));
      vt.push_back(v(0,1,0,0,0,0,0,0, 4'b1000,1,1,0,0));
      vt.push_back(v(0,0,0,0,1,0,1,3, 4'b1000,2,1,0,0));
      vt.push_back(v(0,0,0,0,1,0,1,1, 4'b0010,3,1,0,0));
      vt.push_back(v(1,0,0,0,0,0,0,0, 4'b0000,0,0,0,0));
      foreach (vt[i]) begin
         cyc(vt[i].rs, vt[i].st, vt[i].sp, vt[i].cl, vt[i].c, vt[i].r, vt[i].h, vt[i].s);
         chk($sformatf("vec%0d_cnt_enable", i), 32'(bus.cnt_enable), 32'(vt[i].en));
         chk($sformatf("vec%0d_depth", i), 32'(bus.depth), 32'(vt[i].dp));
         chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vt[i].bz));
         chk($sformatf("vec%0d_err_ovf", i), 32'(bus.err_ovf), 32'(vt[i].er));
         chk($sformatf("vec%0d_cnt_clear", i), 32'(bus.cnt_clear), 32'(vt[i].cc));
      end
      cyc(0,1,0,0,0,0,0,0);
      for (int i = 0; i < 9; i++) cyc(0,0,0,0,1,0,1,2'(i));
      chk("ovf_err", 32'(bus.err_ovf), 1);
      chk("ovf_enable", 32'(bus.cnt_enable), 0);
      chk("ovf_depth", 32'(bus.depth), 8);
      cyc(0,0,0,0,0,1,0,0);
      cyc(0,0,0,0,0,1,0,0);
      chk("halt_ret_depth", 32'(bus.depth), 8);
      cyc(0,0,0,1,0,0,0,0);
      chk("clear_pulse", 32'(bus.cnt_clear), 1);
      cyc(0,0,0,0,0,0,0,0);
      chk("clear_pulse_end", 32'(bus.cnt_clear), 0);
      chk("clear_err", 32'(bus.err_ovf), 0);
      chk("clear_busy", 32'(bus.busy), 0);
      chk("clear_depth", 32'(bus.depth), 0);
      cyc(1,0,0,0,0,0,0,0);
      cyc(0,1,0,0,0,0,0,0);
      cyc(0,0,0,0,1,0,1,1);
      chk("ns3_enable_slot1", 32'(bus3.cnt_enable), 4'b0010);
      cyc(0,0,0,0,1,0,1,3);
      chk("ns3_enable_slot3", 32'(bus3.cnt_enable), 0);
      chk("ns3_depth", 32'(bus3.depth), 2);
      chk("ns4_enable_slot3", 32'(bus.cnt_enable), 4'b1000);
      cyc(1,0,0,0,0,0,0,0);
      for (int k = 0; k < 3000; k++) begin
         rs = $urandom_range(199) == 0;
         cl = $urandom_range(79) == 0;
         sp = $urandom_range(59) == 0;
         st = $urandom_range(7) == 0;
         c  = $urandom_range(99) < 45;
         r  = $urandom_range(99) < 35;
         h  = $urandom_range(3) != 0;
         s  = 2'($urandom_range(3));
         cyc(rs, st, sp, cl, c, r, h, s);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/funprof_sched.md
Name: funprof_sched

Overview:
- Scheduler/controller for the function-profiler counter bank. It sits between the call/return decoder and NUM_SLOTS cycle counters.
- Tracks nesting with a call stack and enables exactly one counter at a time: the counter for the innermost profiled function, giving exclusive time.
- Host start/stop/clear commands sequence the profiling session.

Parameters:
- NUM_SLOTS, 4, number of profiled functions and counters.
- SLOT_W, 2, width of the slot index; must satisfy 2**SLOT_W >= NUM_SLOTS.
- STACK_DEPTH, 8, maximum tracked call nesting.
- DEPTH_W, 4, width of the depth count; must hold the value STACK_DEPTH.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- call  in  1  one-cycle pulse from the decoder: call instruction retired.
- ret  in  1  one-cycle pulse from the decoder: return instruction retired.
- call_hit  in  1  qualifies call: the target is a profiled function.
- call_slot  in  SLOT_W  counter slot of the call target; valid when call && call_hit.
- ctl_start  in  1  host: arm profiling.
- ctl_stop  in  1  host: stop profiling.
- ctl_clear  in  1  host: clear counters and flags.
- cnt_enable  out  NUM_SLOTS  one-hot or zero; registered counter enables.
- cnt_clear  out  1  one-cycle synchronous clear to all counters.
- busy  out  1  high when state != IDLE.
- depth  out  DEPTH_W  current stack depth.
- err_ovf  out  1  sticky flag: stack overflow occurred.

Behaviour:
- Reset values: state IDLE, depth 0, cnt_enable 0, cnt_clear 0, busy 0, err_ovf 0, all stack entries invalid.
- Stack entry format: {valid, slot}.
  - A call with call_hit=1 pushes {1, call_slot}.
  - A call with call_hit=0 pushes {0, x}, so that returns stay balanced.
- States:
  - IDLE: nothing tracked; ctl_start goes to ARMED.
  - ARMED: depth 0. A call with call_hit=1 pushes and goes to RUN. A call with call_hit=0 and any ret are ignored.
  - RUN: every call pushes and every ret pops. A ret that brings depth to 0 returns to ARMED.
  - HALT: entered on overflow. All enables are 0 and trace events are ignored. Only ctl_clear or ctl_stop leave HALT.
  - CLEAR: lasts one cycle, with cnt_clear=1. It empties the stack, sets depth to 0, clears err_ovf, then goes to IDLE.
- Command priority, evaluated each cycle: ctl_clear > ctl_stop > ctl_start > trace events.
  - ctl_clear from any state goes to CLEAR.
  - ctl_stop from any state other than CLEAR goes to IDLE. It empties the stack and sets depth to 0. Counters keep their values and err_ovf is kept.
  - ctl_start is ignored outside IDLE.
  - While any command is asserted, trace events that cycle are dropped.
- Simultaneous call and ret: call wins and ret is ignored.
- Overflow: a call in RUN when depth == STACK_DEPTH sets err_ovf and goes to HALT. Nothing is pushed and depth stays at STACK_DEPTH.
- Enable latency:
  - cnt_enable is registered from the next-state stack top. It changes in the cycle after the call/ret pulse edge, i.e. one clock after the event.
  - cnt_enable = onehot(top.slot) if next state is RUN and top.valid; otherwise 0.
  - Nested calls to the same slot are allowed; the enable stays on.
- A ret in RUN at depth 1 pops to empty, moves to ARMED, and cnt_enable goes to 0.
- call_slot >= NUM_SLOTS with call_hit=1 is treated as call_hit=0.
- Reset mid-RUN discards the stack immediately and returns to IDLE. Reset does not pulse cnt_clear.

Decomposition:
- Shared package funprof_pkg holds:
  - state encoding (IDLE, ARMED, RUN, HALT, CLEAR);
  - stack entry typedef {valid, slot};
  - default NUM_SLOTS and STACK_DEPTH constants.
- Sub-module funprof_stack: a register-based LIFO with push, pop, top, depth and full. It has no combinational path from push/pop to the top output within the same cycle, beyond next-top lookahead for the enable register.

Test Plan:
- Reset, then ctl_start, then a call with hit and slot=2 at cycle t → cnt_enable=4'b0100 from t+1; depth=1; busy=1. Then ret at t+10 → cnt_enable=0 at t+11; state ARMED; depth=0.
- Nesting: call slot 1 → call with hit=0 → call slot 3 → ret → ret → ret. Required cnt_enable sequence: 0010, 0000, 1000, 0000, 0010, 0000. Depth sequence: 1, 2, 3, 2, 1, 0.
- Overflow with STACK_DEPTH=8: 9 hit calls → err_ovf=1 after the 9th; cnt_enable=0; depth=8; later rets ignored. Then ctl_clear → cnt_clear high for exactly 1 cycle; err_ovf=0; busy=0.
- Priority: ctl_stop and a call in the same cycle while in RUN at depth 2 → IDLE, depth 0, cnt_enable 0, call dropped. ctl_start while in RUN → no effect.
- Boundary events:
  - ret in ARMED → ignored, depth stays 0.
  - call and ret in the same cycle in RUN at depth 1 → depth 2.
  - call_slot=3 with NUM_SLOTS=3 → pushed as untracked, so cnt_enable=0.
- Synchronous reset asserted in RUN at depth 3 → next cycle IDLE, depth 0, cnt_enable 0, cnt_clear 0.
